int_to_float_pipe: RTL

Pipelined integer-to-float converter. It accepts a signed or unsigned integer per beat and emits a packed IEEE-754-style float (sign, biased exponent, mantissa). The block sits directly ahead of the float arithmetic units and feeds them normalized operands. Internally it runs a priority leading-one search on the integer magnitude to derive the exponent, then normalizes, rounds and packs the result behind a valid/ready stream handshake.

---
 rtl/int_to_float_pipe.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/int_to_float_pipe.sv
// -----------------------------------------------------------------------------
// int_to_float_pipe
//
// Pipelined integer-to-float converter. Each accepted beat carries one signed
// or unsigned integer. The block emits a packed float {sign, biased exponent,
// mantissa} with the hidden bit not stored. Three registered stages:
//   S1  sign extraction and two's-complement magnitude
//   S2  leading-one search, normalizing shift, guard/round/sticky collapse
//   S3  rounding, exponent bias and packing into the output register
//
// Build option (macro INT_TO_FLOAT_ROUND_NEAREST_EN):
//   defined   -> round-to-nearest-even
//   undefined -> truncate toward zero (no guard/round/sticky, no carry path)
//
// Ports
//   aclk      in   clock, all state on rising edge
//   resetn    in   asynchronous active-low reset
//   s_valid   in   input beat valid
//   s_ready   out  block accepts a beat this cycle
//   s_data    in   integer operand [INT_SIZE-1:0]
//   s_signed  in   1: s_data is two's complement, 0: unsigned
//   m_valid   out  output beat valid
//   m_ready   in   downstream accepts the beat
//   m_data    out  {sign, exponent, mantissa}
//
// Handshake: a beat moves on a channel in any cycle where valid && ready are
// both high at the rising clock edge. Valid, once raised, is held with its
// data stable until ready is seen. All three stages share one advance enable
// ce = !m_valid || m_ready, and s_ready = ce, so s_ready depends
// combinationally on m_ready. Bubbles are not collapsed: each stage valid
// travels with its data and advances on ce even when s_valid is low.
// -----------------------------------------------------------------------------
module int_to_float_pipe #(
  parameter int INT_SIZE      = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23
) (
  input  logic                                 aclk,
  input  logic                                 resetn,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [INT_SIZE-1:0]                  s_data,
  input  logic                                 s_signed,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0] m_data
);

  localparam int PW = (INT_SIZE > 2) ? $clog2(INT_SIZE) : 1;
  localparam int FW = 1 + EXPONENT_SIZE + MANTISSA_SIZE;
  localparam logic [EXPONENT_SIZE-1:0] BIAS =
    EXPONENT_SIZE'((1 << (EXPONENT_SIZE - 1)) - 1);

  logic ce;

  // ---------------------------------------------------------------------------
  // Stage 1: sign and magnitude
  // ---------------------------------------------------------------------------
  logic                v1_d, v1_q;
  logic                sign1_d, sign1_q;
  logic [INT_SIZE-1:0] mag1_d, mag1_q;

  // ---------------------------------------------------------------------------
  // Stage 2: normalized fields
  // ---------------------------------------------------------------------------
  logic                     v2_d, v2_q;
  logic                     sign2_d, sign2_q;
  logic                     zero2_d, zero2_q;
  logic [PW-1:0]            p2_d, p2_q;
  logic [MANTISSA_SIZE-1:0] mant2_d, mant2_q;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
  logic                     guard2_d, guard2_q;
  logic                     rnd2_d, rnd2_q;
  logic                     sticky2_d, sticky2_q;
  logic [PW-1:0]            sh2;
  // Window holds every magnitude bit below the leading one, plus room for
  // the guard and round bits; bits under those collapse into sticky.
  logic [INT_SIZE+MANTISSA_SIZE:0] win2;
`else
  // Only the mantissa window is needed when truncating: right-shifting by p
  // puts the bit just below the leading one at the mantissa MSB.
  logic [INT_SIZE+MANTISSA_SIZE-2:0] win2;
`endif

  // ---------------------------------------------------------------------------
  // Stage 3: packed output
  // ---------------------------------------------------------------------------
  logic                     m_valid_d, m_valid_q;
  logic [FW-1:0]            m_data_d, m_data_q;
  logic [MANTISSA_SIZE-1:0] mant3;
  logic [EXPONENT_SIZE-1:0] exp3;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
  logic                     inc3;
  logic [MANTISSA_SIZE:0]   sum3;
`endif

  assign ce      = !m_valid_q || m_ready;
  assign s_ready = ce;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

  // S1 combinational: the most negative signed value negates to
  // 2^(INT_SIZE-1), which still fits the unsigned magnitude.
  always_comb begin
    v1_d    = s_valid;
    sign1_d = s_signed & s_data[INT_SIZE-1];
    mag1_d  = sign1_d ? (~s_data + INT_SIZE'(1)) : s_data;
  end

  // S2 combinational: priority search, the highest set bit wins.
  always_comb begin
    v2_d    = v1_q;
    sign2_d = sign1_q;
    zero2_d = (mag1_q == '0);
    p2_d    = '0;
    for (int i = 0; i < INT_SIZE; i++) begin
      if (mag1_q[i]) p2_d = PW'(i);
    end
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    sh2       = PW'(INT_SIZE - 1) - p2_d;
    // Bit p itself is left out so the hidden bit falls off the top.
    win2      = {mag1_q[INT_SIZE-2:0], {(MANTISSA_SIZE + 2){1'b0}}} << sh2;
    mant2_d   = win2[INT_SIZE+MANTISSA_SIZE -: MANTISSA_SIZE];
    guard2_d  = win2[INT_SIZE];
    rnd2_d    = win2[INT_SIZE-1];
    sticky2_d = |win2[INT_SIZE-2:0];
`else
    win2    = {mag1_q[INT_SIZE-2:0], {MANTISSA_SIZE{1'b0}}};
    mant2_d = MANTISSA_SIZE'(win2 >> p2_d);
`endif
  end

  // S3 combinational: round, bias, pack. Zero magnitude forces +0.
  always_comb begin
    m_valid_d = v2_q;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
    inc3  = guard2_q & (rnd2_q | sticky2_q | mant2_q[0]);
    sum3  = {1'b0, mant2_q} + {{MANTISSA_SIZE{1'b0}}, inc3};
    // A carry out leaves the low bits at zero and bumps the exponent.
    mant3 = sum3[MANTISSA_SIZE-1:0];
    exp3  = BIAS + EXPONENT_SIZE'(p2_q) + EXPONENT_SIZE'(sum3[MANTISSA_SIZE]);
`else
    mant3 = mant2_q;
    exp3  = BIAS + EXPONENT_SIZE'(p2_q);
`endif
    m_data_d = zero2_q ? '0 : {sign2_q, exp3, mant3};
  end

  // Data registers load only when a valid beat enters them, so bubbles leave
  // the last payload in place; valids advance on every ce.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      v1_q      <= 1'b0;
      sign1_q   <= 1'b0;
      mag1_q    <= '0;
      v2_q      <= 1'b0;
      sign2_q   <= 1'b0;
      zero2_q   <= 1'b0;
      p2_q      <= '0;
      mant2_q   <= '0;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
      guard2_q  <= 1'b0;
      rnd2_q    <= 1'b0;
      sticky2_q <= 1'b0;
`endif
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (ce) begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      m_valid_q <= m_valid_d;
      if (v1_d) begin
        sign1_q <= sign1_d;
        mag1_q  <= mag1_d;
      end
      if (v2_d) begin
        sign2_q   <= sign2_d;
        zero2_q   <= zero2_d;
        p2_q      <= p2_d;
        mant2_q   <= mant2_d;
`ifdef INT_TO_FLOAT_ROUND_NEAREST_EN
        guard2_q  <= guard2_d;
        rnd2_q    <= rnd2_d;
        sticky2_q <= sticky2_d;
`endif
      end
      if (m_valid_d) begin
        m_data_q <= m_data_d;
      end
    end
  end

endmodule
